// File: rtl/wb_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_seq
// Purpose  : Writeback stage. Commits scalar results to a scalar register file
//            in a single cycle. Commits vector results WR_LANES lanes per cycle
//            over BEATS cycles, stalling upstream through in_ready while the
//            narrow write port drains. Two combinational read ports per file
//            serve the decode stage.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            in_valid / in_ready - upstream handshake
//            dest, dest_type, wb - destination register, file select, and
//                                  {vector source select, write enable}
//            mem_data, reg_v     - vector load data / vector ALU result
//            reg_e               - scalar ALU result
//            rd_addr_a/b         - read addresses (shared by both files)
//            rd_e_a/b, rd_v_a/b  - scalar / vector read data (no bypass)
//            wb_escalar          - last committed scalar value
//            wb_vector           - last accepted vector value
//            wb_done             - one-cycle pulse after a write fully commits
//            busy                - multi-beat vector write in progress
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_seq #(
    parameter int SCALAR_W   = 21,
    parameter int LANE_W     = 16,
    parameter int LANES      = 12,
    parameter int REG_ADDR_W = 4,
    parameter int WR_LANES   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_W-1:0]     dest,
    input  logic                      dest_type,
    input  logic [1:0]                wb,
    input  logic [LANES*LANE_W-1:0]   mem_data,
    input  logic [SCALAR_W-1:0]       reg_e,
    input  logic [LANES*LANE_W-1:0]   reg_v,
    input  logic [REG_ADDR_W-1:0]     rd_addr_a,
    input  logic [REG_ADDR_W-1:0]     rd_addr_b,
    output logic [SCALAR_W-1:0]       rd_e_a,
    output logic [SCALAR_W-1:0]       rd_e_b,
    output logic [LANES*LANE_W-1:0]   rd_v_a,
    output logic [LANES*LANE_W-1:0]   rd_v_b,
    output logic [SCALAR_W-1:0]       wb_escalar,
    output logic [LANES*LANE_W-1:0]   wb_vector,
    output logic                      wb_done,
    output logic                      busy
);

    localparam int VW     = LANES * LANE_W;
    localparam int NREGS  = 2 ** REG_ADDR_W;
    localparam int BEATS  = LANES / WR_LANES;
    localparam int GRP_W  = WR_LANES * LANE_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_VWRITE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_beat_nxt;
    logic                    w_done_nxt;

    logic [SCALAR_W-1:0]     r_sfile [NREGS];
    logic [VW-1:0]           r_vfile [NREGS];

    logic [VW-1:0]           r_hold;
    logic [REG_ADDR_W-1:0]   r_hold_dest;
    logic [SCALAR_W-1:0]     r_escalar;
    logic [VW-1:0]           r_wvector;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_scalar_wr;
    logic                    w_vec_acc;
    logic [VW-1:0]           w_vsel;

    // Single narrow vector write port, shared between the accept edge
    // (group 0 straight from the input mux) and the drain beats (from hold).
    logic                    w_vwr_en;
    logic [REG_ADDR_W-1:0]   w_vwr_addr;
    logic [VW-1:0]           w_vwr_data;
    logic [BEAT_W-1:0]       w_vwr_beat;

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_VWRITE);
    assign w_accept    = in_valid & in_ready;
    assign w_scalar_wr = w_accept & wb[0] & ~dest_type;
    assign w_vec_acc   = w_accept & wb[0] & dest_type;
    assign w_vsel      = wb[1] ? mem_data : reg_v;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_scalar_wr) begin
                    w_done_nxt = 1'b1;
                end else if (w_vec_acc) begin
                    if (BEATS == 1) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_VWRITE;
                        w_beat_nxt  = BEAT_W'(1);
                    end
                end
            end
            S_VWRITE: begin
                if (r_beat == c_last_beat) begin
                    w_state_nxt = S_IDLE;
                    w_beat_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_beat_nxt  = r_beat + BEAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vector write port select
    // ------------------------------------------------------------------
    always_comb begin
        w_vwr_en   = 1'b0;
        w_vwr_addr = dest;
        w_vwr_data = w_vsel;
        w_vwr_beat = '0;
        if (r_state == S_VWRITE) begin
            w_vwr_en   = 1'b1;
            w_vwr_addr = r_hold_dest;
            w_vwr_data = r_hold;
            w_vwr_beat = r_beat;
        end else if (w_vec_acc) begin
            w_vwr_en   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register files
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_sfile[r] <= '0;
                r_vfile[r] <= '0;
            end
        end else begin
            if (w_scalar_wr) begin
                r_sfile[dest] <= reg_e;
            end
            if (w_vwr_en) begin
                for (int g = 0; g < BEATS; g++) begin
                    if (w_vwr_beat == BEAT_W'(g)) begin
                        r_vfile[w_vwr_addr][g*GRP_W +: GRP_W] <= w_vwr_data[g*GRP_W +: GRP_W];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold buffer and last-value registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_dest <= '0;
            r_escalar   <= '0;
            r_wvector   <= '0;
        end else begin
            if (w_scalar_wr) begin
                r_escalar <= reg_e;
            end
            if (w_vec_acc) begin
                r_hold      <= w_vsel;
                r_hold_dest <= dest;
                r_wvector   <= w_vsel;
            end
        end
    end

    // Reads come straight from the arrays: a same-cycle write is not visible.
    assign rd_e_a     = r_sfile[rd_addr_a];
    assign rd_e_b     = r_sfile[rd_addr_b];
    assign rd_v_a     = r_vfile[rd_addr_a];
    assign rd_v_b     = r_vfile[rd_addr_b];
    assign wb_escalar = r_escalar;
    assign wb_vector  = r_wvector;
    assign wb_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_seq
// Purpose  : Self-checking bench for wb_stage_seq. A transaction-level model
//            tracks both register files and the remaining lane groups of an
//            in-flight vector write; every cycle the DUT outputs are compared
//            with it, and directed literal checks pin the model itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_seq;

    localparam int SW = 21;
    localparam int VW = 192;
    localparam int NR = 16;
    localparam int NB = 3;
    localparam int GW = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     dest;
    logic           dest_type;
    logic [1:0]     wb;
    logic [VW-1:0]  mem_data;
    logic [SW-1:0]  reg_e;
    logic [VW-1:0]  reg_v;
    logic [3:0]     rd_addr_a;
    logic [3:0]     rd_addr_b;
    logic [SW-1:0]  rd_e_a;
    logic [SW-1:0]  rd_e_b;
    logic [VW-1:0]  rd_v_a;
    logic [VW-1:0]  rd_v_b;
    logic [SW-1:0]  wb_escalar;
    logic [VW-1:0]  wb_vector;
    logic           wb_done;
    logic           busy;

    int errs   = 0;
    int checks = 0;
    logic cmp_en;

    always #5 clk = ~clk;

    wb_stage_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dest       (dest),
        .dest_type  (dest_type),
        .wb         (wb),
        .mem_data   (mem_data),
        .reg_e      (reg_e),
        .reg_v      (reg_v),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_e_a     (rd_e_a),
        .rd_e_b     (rd_e_b),
        .rd_v_a     (rd_v_a),
        .rd_v_b     (rd_v_b),
        .wb_escalar (wb_escalar),
        .wb_vector  (wb_vector),
        .wb_done    (wb_done),
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: files as arrays, a vector write as "groups left".
    // ------------------------------------------------------------------
    logic [SW-1:0]  m_s [NR];
    logic [VW-1:0]  m_v [NR];
    logic [VW-1:0]  m_hold;
    logic [VW-1:0]  m_wvec;
    logic [SW-1:0]  m_esc;
    logic           m_done;
    int             m_left;
    int             m_grp;
    int             m_dest;

    function automatic logic [VW-1:0] pick(input logic sel, input logic [VW-1:0] m, input logic [VW-1:0] a);
        return sel ? m : a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                m_s[r] <= '0;
                m_v[r] <= '0;
            end
            m_hold <= '0;
            m_wvec <= '0;
            m_esc  <= '0;
            m_done <= 1'b0;
            m_left <= 0;
            m_grp  <= 0;
            m_dest <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_v[m_dest][m_grp*GW +: GW] <= m_hold[m_grp*GW +: GW];
                m_grp  <= m_grp + 1;
                m_left <= m_left - 1;
                if (m_left == 1) m_done <= 1'b1;
            end else if (in_valid && wb[0]) begin
                if (!dest_type) begin
                    m_s[dest] <= reg_e;
                    m_esc     <= reg_e;
                    m_done    <= 1'b1;
                end else begin
                    m_v[dest][GW-1:0] <= pick(wb[1], mem_data, reg_v) & {{(VW-GW){1'b0}}, {GW{1'b1}}}
                                         | (m_v[dest] & {{(VW-GW){1'b1}}, {GW{1'b0}}});
                    m_wvec <= pick(wb[1], mem_data, reg_v);
                    m_hold <= pick(wb[1], mem_data, reg_v);
                    m_dest <= int'(dest);
                    m_grp  <= 1;
                    m_left <= NB - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",   VW'(in_ready),   VW'(m_left == 0));
            chk("busy",       VW'(busy),       VW'(m_left != 0));
            chk("wb_done",    VW'(wb_done),    VW'(m_done));
            chk("wb_escalar", VW'(wb_escalar), VW'(m_esc));
            chk("wb_vector",  wb_vector,       m_wvec);
            chk("rd_e_a",     VW'(rd_e_a),     VW'(m_s[rd_addr_a]));
            chk("rd_e_b",     VW'(rd_e_b),     VW'(m_s[rd_addr_b]));
            chk("rd_v_a",     rd_v_a,          m_v[rd_addr_a]);
            chk("rd_v_b",     rd_v_b,          m_v[rd_addr_b]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    logic [VW-1:0] mv;
    logic [VW-1:0] lo1;
    logic [VW-1:0] lo2;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; dest = '0; dest_type = 1'b0; wb = 2'b00;
        mem_data = '0; reg_e = '0; reg_v = '0; rd_addr_a = '0; rd_addr_b = '0;
        cmp_en = 1'b0;
        lo1 = {{(VW-GW){1'b0}}, {GW{1'b1}}};
        lo2 = {{(VW-2*GW){1'b0}}, {(2*GW){1'b1}}};
        for (int i = 0; i < 12; i++) mv[i*16 +: 16] = 16'h1000 + 16'(i);

        // Reset released mid-cycle
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", VW'(in_ready), VW'(1'b1));
        chk("rst_busy",     VW'(busy),     VW'(1'b0));
        chk("rst_done",     VW'(wb_done),  VW'(1'b0));
        chk("rst_rd_e_a",   VW'(rd_e_a),   '0);
        chk("rst_rd_v_a",   rd_v_a,        '0);
        chk("rst_wb_vec",   wb_vector,     '0);
        #1;

        // Scalar writes, back to back
        in_valid = 1'b1; dest = 4'd3; dest_type = 1'b0; wb = 2'b01; reg_e = 21'h1ABCD;
        rd_addr_a = 4'd3; rd_addr_b = 4'd4;
        tick();
        dest = 4'd4; reg_e = 21'h00055;
        @(negedge clk);
        chk("sc_rd_e_a",   VW'(rd_e_a),     VW'(21'h1ABCD));
        chk("sc_escalar",  VW'(wb_escalar), VW'(21'h1ABCD));
        chk("sc_done",     VW'(wb_done),    VW'(1'b1));
        chk("sc_rd_e_b0",  VW'(rd_e_b),     '0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sc2_rd_e_b",  VW'(rd_e_b),     VW'(21'h00055));
        chk("sc2_done",    VW'(wb_done),    VW'(1'b1));
        tick();
        @(negedge clk);
        chk("sc3_done",    VW'(wb_done),    VW'(1'b0));

        // Vector from memory data; ALU data differs to expose the mux
        tick();
        in_valid = 1'b1; dest = 4'd5; dest_type = 1'b1; wb = 2'b11;
        mem_data = mv; reg_v = {12{16'hDEAD}}; rd_addr_a = 4'd5;
        tick();
        in_valid = 1'b0; mem_data = '1; reg_v = '0;
        @(negedge clk);
        chk("vm_ready0", VW'(in_ready), VW'(1'b0));
        chk("vm_busy0",  VW'(busy),     VW'(1'b1));
        chk("vm_beat0",  rd_v_a,        mv & lo1);
        chk("vm_wbvec",  wb_vector,     mv);
        tick();
        @(negedge clk);
        chk("vm_ready1", VW'(in_ready), VW'(1'b0));
        chk("vm_beat1",  rd_v_a,        mv & lo2);
        tick();
        @(negedge clk);
        chk("vm_ready2", VW'(in_ready), VW'(1'b1));
        chk("vm_done",   VW'(wb_done),  VW'(1'b1));
        chk("vm_full",   rd_v_a,        mv);

        // Vector from ALU, in_valid held high while busy
        tick();
        in_valid = 1'b1; dest = 4'd6; dest_type = 1'b1; wb = 2'b01;
        reg_v = {12{16'hBEEF}}; mem_data = '0; rd_addr_a = 4'd6; rd_addr_b = 4'd7;
        tick();
        dest = 4'd7; reg_v = {12{16'h1111}};
        tick();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("va_full",   rd_v_a,       {12{16'hBEEF}});
        chk("va_noacc",  rd_v_b,       '0);
        chk("va_done",   VW'(wb_done), VW'(1'b1));
        chk("va_wbvec",  wb_vector,    {12{16'hBEEF}});
        tick();
        @(negedge clk);
        chk("va_noacc2", rd_v_b,       '0);

        // Write enable clear: nothing changes
        tick();
        in_valid = 1'b1; dest = 4'd2; dest_type = 1'b1; wb = 2'b10; mem_data = '1; rd_addr_a = 4'd2;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("nw_rd_v",   rd_v_a,        '0);
        chk("nw_done",   VW'(wb_done),  VW'(1'b0));
        chk("nw_ready",  VW'(in_ready), VW'(1'b1));
        chk("nw_wbvec",  wb_vector,     {12{16'hBEEF}});

        // Reset in the middle of a vector write
        tick();
        in_valid = 1'b1; dest = 4'd8; dest_type = 1'b1; wb = 2'b01;
        reg_v = {12{16'hAAAA}}; rd_addr_a = 4'd8; rd_addr_b = 4'd3;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rm_beat1",  rd_v_a,        {12{16'hAAAA}} & lo2);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_rd_v",   rd_v_a,        '0);
        chk("rm_rd_e",   VW'(rd_e_b),   '0);
        chk("rm_busy",   VW'(busy),     VW'(1'b0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        in_valid = 1'b1; dest = 4'd9; dest_type = 1'b0; wb = 2'b01; reg_e = 21'h0F0F0;
        rd_addr_a = 4'd9; rd_addr_b = 4'd8;
        @(negedge clk);
        chk("rm_ready",  VW'(in_ready), VW'(1'b1));
        chk("rm_done0",  VW'(wb_done),  VW'(1'b0));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rm_sc",     VW'(rd_e_a),   VW'(21'h0F0F0));
        chk("rm_done1",  VW'(wb_done),  VW'(1'b1));
        chk("rm_v8",     rd_v_b,        '0);
        tick();
        tick();
        @(negedge clk);
        chk("rm_v8b",    rd_v_b,        '0);

        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
